// File: rtl/axi3_pkg.sv
// axi3_pkg: shared AXI3 encodings and the LED responder register map.
// Contents: burst and response codes, ID/LEN widths, and the led_regs
// register index group (index = address bits [3:2]).
package axi3_pkg;

  localparam int ID_W  = 12;
  localparam int LEN_W = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // led_regs: word index of each register; byte offset = index * 4
  typedef enum logic [1:0] {
    REG_LED  = 2'd0,
    REG_MODE = 2'd1,
    REG_DIV  = 2'd2,
    REG_ID   = 2'd3
  } led_regs_e;

endpackage

// File: rtl/axi3_burst_addr.sv
// axi3_burst_addr: next beat address for an AXI3 burst.
// Ports:
//   addr      in  32  current beat address
//   size      in  3   beat size code (bytes = 1 << size)
//   burst     in  2   burst type
//   next_addr out 32  address of the following beat
//   legal     out 1   1 for FIXED/INCR; WRAP and reserved bursts are refused
module axi3_burst_addr
  import axi3_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        legal
);

  always_comb begin
    next_addr = addr;
    legal     = 1'b0;
    case (burst)
      BURST_FIXED: legal = 1'b1;
      BURST_INCR: begin
        legal     = 1'b1;
        next_addr = addr + (32'd1 << size);
      end
      BURST_WRAP: legal = 1'b0;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi3_led_responder.sv
// axi3_led_responder: AXI3 slave on a PS7 GP master port, holding a 4-word
// register file (LED, MODE, DIV, ID) and driving 8 LEDs with optional blink.
// Ports:
//   i_clk0, i_rst                 clock, synchronous active-high reset
//   i_AW*/o_AWREADY               write address channel
//   i_W*/o_WREADY                 write data channel (WID ignored)
//   o_B*/i_BREADY                 write response channel
//   i_AR*/o_ARREADY               read address channel
//   o_R*/i_RREADY                 read data channel
//   o_led                         registered LED drive
//   LOCK/CACHE/PROT/QOS/WID       connection only, ignored
//
// state  | meaning
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, accepting write beats
// W_RESP | BVALID high until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high, presenting beats until the RLAST handshake
module axi3_led_responder
  import axi3_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = 32'h4C454438,
  parameter logic [7:0]  LED_RESET = 8'h00,
  parameter logic [31:0] DIV_RESET = 32'd49999999
) (
  input  logic             i_clk0,
  input  logic             i_rst,
  input  logic             i_AWVALID,
  input  logic [ID_W-1:0]  i_AWID,
  input  logic [31:0]      i_AWADDR,
  input  logic [LEN_W-1:0] i_AWLEN,
  input  logic [2:0]       i_AWSIZE,
  input  logic [1:0]       i_AWBURST,
  input  logic [1:0]       i_AWLOCK,
  input  logic [3:0]       i_AWCACHE,
  input  logic [2:0]       i_AWPROT,
  input  logic [3:0]       i_AWQOS,
  output logic             o_AWREADY,
  input  logic             i_WVALID,
  input  logic [ID_W-1:0]  i_WID,
  input  logic [31:0]      i_WDATA,
  input  logic [3:0]       i_WSTRB,
  input  logic             i_WLAST,
  output logic             o_WREADY,
  output logic             o_BVALID,
  output logic [ID_W-1:0]  o_BID,
  output logic [1:0]       o_BRESP,
  input  logic             i_BREADY,
  input  logic             i_ARVALID,
  input  logic [ID_W-1:0]  i_ARID,
  input  logic [31:0]      i_ARADDR,
  input  logic [LEN_W-1:0] i_ARLEN,
  input  logic [2:0]       i_ARSIZE,
  input  logic [1:0]       i_ARBURST,
  input  logic [1:0]       i_ARLOCK,
  input  logic [3:0]       i_ARCACHE,
  input  logic [2:0]       i_ARPROT,
  input  logic [3:0]       i_ARQOS,
  output logic             o_ARREADY,
  output logic             o_RVALID,
  output logic [ID_W-1:0]  o_RID,
  output logic [31:0]      o_RDATA,
  output logic [1:0]       o_RRESP,
  output logic             o_RLAST,
  input  logic             i_RREADY,
  output logic [7:0]       o_led
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Exclusive/decode responses are never generated; sideband inputs are ignored.
  logic unused_ok;
  assign unused_ok = ^{i_WID, i_AWLOCK, i_AWCACHE, i_AWPROT, i_AWQOS,
                       i_ARLOCK, i_ARCACHE, i_ARPROT, i_ARQOS,
                       RESP_EXOKAY, RESP_DECERR};

  logic [7:0]  led_q;
  logic        mode_q;
  logic [31:0] div_q;
  logic [31:0] blink_cnt;
  logic        phase;

  function automatic logic [31:0] reg_rd(input logic [1:0] idx, input logic [7:0] led,
                                         input logic mode, input logic [31:0] div);
    case (led_regs_e'(idx))
      REG_LED:  return {24'h0, led};
      REG_MODE: return {31'h0, mode};
      REG_DIV:  return div;
      REG_ID:   return ID_VALUE;
      default:  return 32'h0;
    endcase
  endfunction

  // ---------------- write path ----------------
  w_state_e         w_state;
  logic [ID_W-1:0]  aw_id_q;
  logic [31:0]      aw_addr_q;
  logic [LEN_W-1:0] aw_len_q;
  logic [2:0]       aw_size_q;
  logic [1:0]       aw_burst_q;
  logic [LEN_W-1:0] w_beat_q;
  logic [31:0]      w_next_addr;
  logic             w_legal;
  logic             w_hs;
  logic             w_count_end;
  logic             reg_we;
  led_regs_e        w_idx;

  axi3_burst_addr u_w_addr (
    .addr      (aw_addr_q),
    .size      (aw_size_q),
    .burst     (aw_burst_q),
    .next_addr (w_next_addr),
    .legal     (w_legal)
  );

  assign w_hs        = (w_state == W_DATA) && o_WREADY && i_WVALID;
  assign w_count_end = (w_beat_q == aw_len_q);
  assign reg_we      = w_hs && w_legal;
  assign w_idx       = led_regs_e'(aw_addr_q[3:2]);

  always_ff @(posedge i_clk0) begin
    if (i_rst) begin
      w_state    <= W_IDLE;
      o_AWREADY  <= 1'b0;
      o_WREADY   <= 1'b0;
      o_BVALID   <= 1'b0;
      o_BID      <= '0;
      o_BRESP    <= RESP_OKAY;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_beat_q   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          o_AWREADY <= 1'b1;
          if (o_AWREADY && i_AWVALID) begin
            aw_id_q    <= i_AWID;
            aw_addr_q  <= i_AWADDR;
            aw_len_q   <= i_AWLEN;
            aw_size_q  <= i_AWSIZE;
            aw_burst_q <= i_AWBURST;
            w_beat_q   <= '0;
            o_AWREADY  <= 1'b0;
            o_WREADY   <= 1'b1;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            aw_addr_q <= w_next_addr;
            // The burst ends on whichever comes first, the beat count or WLAST;
            // a mismatch between the two can only show up on that final beat.
            if (w_count_end || i_WLAST) begin
              o_WREADY <= 1'b0;
              o_BVALID <= 1'b1;
              o_BID    <= aw_id_q;
              o_BRESP  <= (w_legal && (w_count_end == i_WLAST)) ? RESP_OKAY : RESP_SLVERR;
              w_state  <= W_RESP;
            end else begin
              w_beat_q <= w_beat_q + 1'b1;
            end
          end
        end
        W_RESP: begin
          if (i_BREADY) begin
            o_BVALID  <= 1'b0;
            o_AWREADY <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  r_state_e         r_state;
  logic [31:0]      ar_addr_q;
  logic [LEN_W-1:0] ar_len_q;
  logic [2:0]       ar_size_q;
  logic [1:0]       ar_burst_q;
  logic [LEN_W-1:0] r_beat_q;
  logic [31:0]      r_addr_cur;
  logic [2:0]       r_size_cur;
  logic [1:0]       r_burst_cur;
  logic [31:0]      r_next_addr;
  logic             r_legal;

  // In R_IDLE the address unit looks at the incoming AR so the first beat's
  // legality is known at the handshake; afterwards it follows the latched burst.
  always_comb begin
    r_addr_cur  = ar_addr_q;
    r_size_cur  = ar_size_q;
    r_burst_cur = ar_burst_q;
    if (r_state == R_IDLE) begin
      r_addr_cur  = i_ARADDR;
      r_size_cur  = i_ARSIZE;
      r_burst_cur = i_ARBURST;
    end
  end

  axi3_burst_addr u_r_addr (
    .addr      (r_addr_cur),
    .size      (r_size_cur),
    .burst     (r_burst_cur),
    .next_addr (r_next_addr),
    .legal     (r_legal)
  );

  always_ff @(posedge i_clk0) begin
    if (i_rst) begin
      r_state    <= R_IDLE;
      o_ARREADY  <= 1'b0;
      o_RVALID   <= 1'b0;
      o_RID      <= '0;
      o_RDATA    <= '0;
      o_RRESP    <= RESP_OKAY;
      o_RLAST    <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_beat_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          o_ARREADY <= 1'b1;
          if (o_ARREADY && i_ARVALID) begin
            ar_addr_q  <= i_ARADDR;
            ar_len_q   <= i_ARLEN;
            ar_size_q  <= i_ARSIZE;
            ar_burst_q <= i_ARBURST;
            r_beat_q   <= '0;
            o_ARREADY  <= 1'b0;
            o_RVALID   <= 1'b1;
            o_RID      <= i_ARID;
            o_RDATA    <= r_legal ? reg_rd(i_ARADDR[3:2], led_q, mode_q, div_q) : 32'h0;
            o_RRESP    <= r_legal ? RESP_OKAY : RESP_SLVERR;
            o_RLAST    <= (i_ARLEN == '0);
            r_state    <= R_DATA;
          end
        end
        R_DATA: begin
          if (i_RREADY) begin
            if (o_RLAST) begin
              o_RVALID  <= 1'b0;
              o_RLAST   <= 1'b0;
              o_ARREADY <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              ar_addr_q <= r_next_addr;
              r_beat_q  <= r_beat_q + 1'b1;
              o_RDATA   <= r_legal ? reg_rd(r_next_addr[3:2], led_q, mode_q, div_q) : 32'h0;
              o_RLAST   <= ((r_beat_q + 1'b1) == ar_len_q);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- register file, blink, LED drive ----------------
  always_ff @(posedge i_clk0) begin
    if (i_rst) begin
      led_q     <= LED_RESET;
      mode_q    <= 1'b0;
      div_q     <= DIV_RESET;
      blink_cnt <= '0;
      phase     <= 1'b1;
      o_led     <= LED_RESET;
    end else begin
      if (reg_we) begin
        case (w_idx)
          REG_LED:  if (i_WSTRB[0]) led_q <= i_WDATA[7:0];
          REG_MODE: if (i_WSTRB[0]) mode_q <= i_WDATA[0];
          REG_DIV: begin
            for (int b = 0; b < 4; b++) begin
              if (i_WSTRB[b]) div_q[8*b +: 8] <= i_WDATA[8*b +: 8];
            end
          end
          default: ;
        endcase
      end

      if (!mode_q) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (reg_we && (w_idx == REG_DIV)) begin
        blink_cnt <= '0;
      end else if (blink_cnt == div_q) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end

      o_led <= led_q & {8{phase}};
    end
  end

endmodule
